// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a five-stage pipeline.
// Tracks the instructions in MEM (EM) and WB (MW) and picks, per EX operand,
// the youngest in-flight producer of that register. A load sitting in MEM
// cannot be forwarded yet, so a read of its destination raises stall for one
// cycle; the load data is picked up from MW on the following cycle.
module fwd_hazard_unit #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int NUM_OPS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_OPS*REG_AW-1:0]   ex_rs,
    input  logic [NUM_OPS*DATA_W-1:0]   ex_op,
    input  logic                        ex_valid,
    input  logic                        ex_we,
    input  logic                        ex_load,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic [DATA_W-1:0]           ex_result,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        flush,
    output logic [NUM_OPS*2-1:0]        fwd_sel,
    output logic [NUM_OPS*DATA_W-1:0]   fwd_op,
    output logic                        stall,
    output logic [15:0]                 stall_cnt
);

    // Operand source encodings.
    localparam logic [1:0] SEL_IDEX = 2'b00;
    localparam logic [1:0] SEL_EM   = 2'b10;
    localparam logic [1:0] SEL_MW   = 2'b01;

    // Stall cycle counter holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Register 0 never matches a producer: it reads as the ID/EX value.
    function automatic logic reg_match(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return (rs != '0) && (rd == rs);
    endfunction

    // EX/MEM stage (_p1): instruction currently in MEM.
    logic               em_vld_p1;
    logic               em_we_p1;
    logic               em_load_p1;
    logic [REG_AW-1:0]  em_rd_p1;
    logic [DATA_W-1:0]  em_data_p1;

    // MEM/WB stage (_p2): instruction currently in WB, load data resolved.
    logic               mw_vld_p2;
    logic               mw_we_p2;
    logic [REG_AW-1:0]  mw_rd_p2;
    logic [DATA_W-1:0]  mw_data_p2;

    // Per-operand hit vectors.
    logic [NUM_OPS-1:0] em_alu_hit;
    logic [NUM_OPS-1:0] em_ld_hit;
    logic [NUM_OPS-1:0] mw_hit;

    // Classify each operand against the MEM and WB producers.
    always_comb begin
        em_alu_hit = '0;
        em_ld_hit  = '0;
        mw_hit     = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (em_vld_p1 && em_we_p1 && reg_match(em_rd_p1, ex_rs[i*REG_AW +: REG_AW])) begin
                em_alu_hit[i] = !em_load_p1;
                em_ld_hit[i]  = em_load_p1;
            end
            mw_hit[i] = mw_vld_p2 && mw_we_p2 && reg_match(mw_rd_p2, ex_rs[i*REG_AW +: REG_AW]);
        end
    end

    // Priority mux: MEM result beats WB result beats the ID/EX latched value.
    // A load in MEM is skipped here, so an older WB producer may still win.
    always_comb begin
        fwd_sel = '0;
        fwd_op  = ex_op;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (em_alu_hit[i]) begin
                fwd_sel[i*2 +: 2]         = SEL_EM;
                fwd_op[i*DATA_W +: DATA_W] = em_data_p1;
            end else if (mw_hit[i]) begin
                fwd_sel[i*2 +: 2]         = SEL_MW;
                fwd_op[i*DATA_W +: DATA_W] = mw_data_p2;
            end else begin
                fwd_sel[i*2 +: 2]         = SEL_IDEX;
            end
        end
    end

    // Load-use hazard: any operand of a valid EX instruction needs the load in MEM.
    always_comb begin
        stall = ex_valid && (|em_ld_hit);
    end

    // ---- EX -> MEM boundary ----
    // Capture the EX instruction; a stall or flush inserts a bubble instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_vld_p1  <= 1'b0;
            em_we_p1   <= 1'b0;
            em_load_p1 <= 1'b0;
            em_rd_p1   <= '0;
            em_data_p1 <= '0;
        end else begin
            em_vld_p1  <= ex_valid && !stall && !flush;
            em_we_p1   <= ex_we;
            em_load_p1 <= ex_load;
            em_rd_p1   <= ex_rd;
            em_data_p1 <= ex_result;
        end
    end

    // ---- MEM -> WB boundary ----
    // Advance MEM into WB, substituting the memory read data for loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_vld_p2  <= 1'b0;
            mw_we_p2   <= 1'b0;
            mw_rd_p2   <= '0;
            mw_data_p2 <= '0;
        end else begin
            mw_vld_p2  <= em_vld_p1;
            mw_we_p2   <= em_we_p1;
            mw_rd_p2   <= em_rd_p1;
            mw_data_p2 <= em_load_p1 ? mem_rdata : em_data_p1;
        end
    end

    // Count stall cycles, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, async-reset sequence,
// and a randomized run compared against an in-flight-instruction model.
module tb_fwd_hazard_unit;

    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int NUM_OPS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   ex_rs;
    logic [31:0]  ex_op;
    logic         ex_valid, ex_we, ex_load;
    logic [3:0]   ex_rd;
    logic [15:0]  ex_result, mem_rdata;
    logic         flush;
    logic [3:0]   fwd_sel;
    logic [31:0]  fwd_op;
    logic         stall;
    logic [15:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_OPS(NUM_OPS)) dut (
        .clk(clk), .rst(rst), .ex_rs(ex_rs), .ex_op(ex_op),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_load(ex_load), .ex_rd(ex_rd),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .flush(flush),
        .fwd_sel(fwd_sel), .fwd_op(fwd_op), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  rs;
        logic [31:0] op;
        logic        v, we, ld;
        logic [3:0]  rd;
        logic [15:0] res, mrd;
        logic        fl;
        logic [3:0]  e_sel;
        logic [31:0] e_op;
        logic        e_stall;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    // Reference model: the two in-flight instructions, youngest first.
    typedef struct packed {
        logic        v, we, ld;
        logic [3:0]  rd;
        logic [15:0] d;
    } slot_t;
    slot_t       age[2];
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_rs = v.rs; ex_op = v.op; ex_valid = v.v; ex_we = v.we; ex_load = v.ld;
        ex_rd = v.rd; ex_result = v.res; mem_rdata = v.mrd; flush = v.fl;
    endtask

    task automatic drive_instr(input logic [7:0] rs, input logic [31:0] op, input logic v,
                               input logic we, input logic ld, input logic [3:0] rd,
                               input logic [15:0] res);
        ex_rs = rs; ex_op = op; ex_valid = v; ex_we = we; ex_load = ld;
        ex_rd = rd; ex_result = res; mem_rdata = 16'h0; flush = 1'b0;
    endtask

    // Expected outputs: search in-flight producers youngest first; a load still
    // in MEM is not forwardable and instead signals a stall.
    task automatic model_eval(output logic [3:0] e_sel, output logic [31:0] e_op,
                              output logic e_stall);
        logic [3:0] rs;
        logic       found;
        e_sel = 4'h0; e_op = ex_op; e_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = ex_rs[i*4 +: 4];
            found = 1'b0;
            if (rs != 4'h0) begin
                for (int a = 0; a < 2; a++) begin
                    if (!found && age[a].v && age[a].we && age[a].rd == rs) begin
                        if (a == 0 && age[a].ld) begin
                            if (ex_valid) e_stall = 1'b1;
                        end else begin
                            found = 1'b1;
                            e_sel[i*2 +: 2] = (a == 0) ? 2'b10 : 2'b01;
                            e_op[i*16 +: 16] = age[a].d;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_step(input logic st);
        slot_t older;
        older = age[0];
        if (older.ld) older.d = mem_rdata;
        age[1] = older;
        age[0] = '{ex_valid && !st && !flush, ex_we, ex_load, ex_rd, ex_result};
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    logic [3:0]  e_sel;
    logic [31:0] e_op;
    logic        e_stall;

    initial begin
        //         rs     op             v     we    ld    rd    res       mrd       fl    sel   op             st    cnt
        tbl[0]  = '{8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 16'd0};
        tbl[1]  = '{8'h00, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 4'h3, 16'h000A, 16'h0000, 1'b0, 4'h0, 32'h1111_2222, 1'b0, 16'd0};
        tbl[2]  = '{8'h43, 32'h0044_0013, 1'b1, 1'b1, 1'b0, 4'h7, 16'h0777, 16'h0000, 1'b0, 4'h2, 32'h0044_000A, 1'b0, 16'd0};
        tbl[3]  = '{8'h73, 32'h0070_0013, 1'b1, 1'b1, 1'b0, 4'h3, 16'h0009, 16'h0000, 1'b0, 4'h9, 32'h0777_000A, 1'b0, 16'd0};
        tbl[4]  = '{8'h73, 32'h0070_0013, 1'b1, 1'b1, 1'b0, 4'h3, 16'h0006, 16'h0000, 1'b0, 4'h6, 32'h0777_0009, 1'b0, 16'd0};
        tbl[5]  = '{8'h03, 32'h0055_0013, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h2, 32'h0055_0006, 1'b0, 16'd0};
        tbl[6]  = '{8'h00, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'h0, 16'h00FF, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 16'd0};
        tbl[7]  = '{8'h00, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 32'h0001_0000, 1'b0, 16'd0};
        tbl[8]  = '{8'h00, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 4'h5, 16'hDEAD, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 16'd0};
        tbl[9]  = '{8'h05, 32'h0000_0050, 1'b1, 1'b1, 1'b0, 4'h6, 16'h0666, 16'h1234, 1'b0, 4'h0, 32'h0000_0050, 1'b1, 16'd0};
        tbl[10] = '{8'h05, 32'h0000_0050, 1'b1, 1'b1, 1'b0, 4'h6, 16'h0666, 16'h0000, 1'b0, 4'h1, 32'h0000_1234, 1'b0, 16'd1};
        tbl[11] = '{8'h00, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'h3, 16'h000A, 16'h0000, 1'b1, 4'h0, 32'h0000_0000, 1'b0, 16'd1};
        tbl[12] = '{8'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 16'd1};
        tbl[13] = '{8'h63, 32'h0060_0013, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 4'h0, 32'h0060_0013, 1'b0, 16'd1};

        // Reset state
        rst = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset sel", 32'(fwd_sel), 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            chk($sformatf("v%0d sel", i), 32'(fwd_sel), 32'(tbl[i].e_sel));
            chk($sformatf("v%0d op", i), fwd_op, tbl[i].e_op);
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
        end

        // Async reset in the middle of a load-use stall
        @(negedge clk);
        drive_instr(8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 4'h4, 16'h0044);
        @(negedge clk);
        drive_instr(8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 4'h5, 16'hDEAD);
        @(negedge clk);
        drive_instr(8'h45, 32'h4040_5050, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #2;
        chk("pre-rst stall", 32'(stall), 32'h1);
        chk("pre-rst sel", 32'(fwd_sel), 32'h4);
        chk("pre-rst op", fwd_op, 32'h0044_5050);
        chk("pre-rst cnt", 32'(stall_cnt), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async rst stall", 32'(stall), 32'h0);
        chk("async rst sel", 32'(fwd_sel), 32'h0);
        chk("async rst op", fwd_op, 32'h4040_5050);
        chk("async rst cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        drive_instr(8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 4'h3, 16'h0BEE);
        #2;
        chk("post-rst sel", 32'(fwd_sel), 32'h0);
        chk("post-rst stall", 32'(stall), 32'h0);
        @(negedge clk);
        drive_instr(8'h03, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #2;
        chk("post-rst fwd sel", 32'(fwd_sel), 32'h2);
        chk("post-rst fwd op", fwd_op, 32'h0000_0BEE);
        chk("post-rst cnt", 32'(stall_cnt), 32'h0);

        // Randomized run against the model
        @(negedge clk);
        rst = 1'b1;
        drive(tbl[0]);
        @(negedge clk);
        rst = 1'b0;
        age[0] = '0;
        age[1] = '0;
        m_cnt  = 16'd0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            ex_rs     = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            ex_op     = $urandom;
            ex_valid  = ($urandom_range(0, 9) < 8);
            ex_we     = ($urandom_range(0, 9) < 7);
            ex_load   = ($urandom_range(0, 3) == 0);
            ex_rd     = 4'($urandom_range(0, 5));
            ex_result = 16'($urandom);
            mem_rdata = 16'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            #2;
            model_eval(e_sel, e_op, e_stall);
            chk($sformatf("rnd%0d sel", n), 32'(fwd_sel), 32'(e_sel));
            chk($sformatf("rnd%0d op", n), fwd_op, e_op);
            chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(e_stall));
            chk($sformatf("rnd%0d cnt", n), 32'(stall_cnt), 32'(m_cnt));
            model_step(e_stall);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter DATA_W, default 16: operand and result data width.
REQ-002 Parameter REG_AW, default 4: register-address width; register 0 is hardwired zero.
REQ-003 Parameter NUM_OPS, default 2: number of EX-stage source operands forwarded.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port ex_rs  input  NUM_OPS*REG_AW: source register address per operand of the instruction in EX; operand i at bits [i*REG_AW +: REG_AW].
REQ-007 Port ex_op  input  NUM_OPS*DATA_W: ID/EX-latched operand value per operand; same packing as ex_rs.
REQ-008 Port ex_valid, ex_we, ex_load  input  1 each: EX instruction valid, writes a register, is a load.
REQ-009 Port ex_rd  input  REG_AW: EX instruction destination register.
REQ-010 Port ex_result  input  DATA_W: EX ALU result.
REQ-011 Port mem_rdata  input  DATA_W: data-memory read data for the instruction currently in MEM.
REQ-012 Port flush  input  1: squash the instruction in MEM on the next edge.
REQ-013 Port fwd_sel  output  NUM_OPS*2: per-operand select; 00 ID/EX, 10 EX/MEM, 01 MEM/WB.
REQ-014 Port fwd_op  output  NUM_OPS*DATA_W: forwarded operand values.
REQ-015 Port stall  output  1: load-use hazard; the external pipeline holds IF/ID/EX.
REQ-016 Port stall_cnt  output  16: count of stall cycles since reset.

Function
REQ-017 Internal EM register set {valid, we, load, rd, data}; on each edge it captures {ex_valid, ex_we, ex_load, ex_rd, ex_result}.
REQ-018 When stall=1 or flush=1 at an edge, EM.valid loads 0 (bubble); other EM fields are don't-care.
REQ-019 Internal MW register set {valid, we, rd, data}; on each edge it captures EM, with MW.data = EM.load ? mem_rdata : EM.data.
REQ-020 EM-hit(i): EM.valid & EM.we & !EM.load & EM.rd==rs(i) & rs(i)!=0.
REQ-021 MW-hit(i): MW.valid & MW.we & MW.rd==rs(i) & rs(i)!=0.
REQ-022 Selection is combinational with priority EM-hit (sel 10, data EM.data), then MW-hit (sel 01, data MW.data), else sel 00, data ex_op(i).
REQ-023 stall = ex_valid & OR over i of (EM.valid & EM.we & EM.load & EM.rd==rs(i) & rs(i)!=0); combinational, no added latency.
REQ-024 During stall, fwd_sel/fwd_op still follow REQ-022; the load in EM is not forwarded.
REQ-025 Load-use resolution takes exactly one stall cycle; on the following cycle the operand takes MW-hit (sel 01) with the load data.
REQ-026 stall_cnt increments by 1 on each edge where stall=1 and saturates at 16'hFFFF.
REQ-027 rs(i)==0 always yields sel 00 and ex_op(i), regardless of EM/MW contents.
REQ-028 Operands are independent; different operands may hit different stages in the same cycle.
REQ-029 Simultaneous flush and stall: EM bubble as in REQ-018; stall_cnt still increments.

Reset
REQ-030 On rst assertion, immediately: EM.valid=0, MW.valid=0, all EM/MW data and rd=0, stall_cnt=0; hence stall=0 and fwd_sel=00 for all operands.
REQ-031 Reset asserted mid-stall clears the hazard immediately; the first edge after deassertion resumes normal capture.

Verification
REQ-032 ALU chain: EX r3<=0x000A, next cycle EX reads rs0=r3, ex_op0=0x0013 -> sel0=10, fwd_op0=0x000A, stall=0.
REQ-033 Distance two: r3<=0x000A, one unrelated instruction, then read r3 -> sel0=01, fwd_op0=0x000A; same-rd in EM (0x0006) and MW -> EM wins, fwd_op0=0x0006.
REQ-034 Load-use: load r5 (mem_rdata=0x1234) then read r5 -> stall=1 one cycle, stall_cnt=1; next cycle sel0=01, fwd_op0=0x1234, stall=0.
REQ-035 r0: write r0<=0x00FF then read r0 with ex_op0=0x0000 -> sel0=00, fwd_op0=0x0000.
REQ-036 Flush: r3<=0x000A, flush=1, then read r3 two cycles later -> sel0=00, fwd_op0=ex_op0.
REQ-037 Async reset asserted mid-stall between edges -> stall, stall_cnt, fwd_sel clear to 0 without a clock edge.
